// File: rtl/sdram_ctrl_pkg.sv
`default_nettype none
// +-----------------------------------------------------------------+
// | sdram_ctrl_pkg : shared SDRAM controller types and defaults      |
// | Rev 1.0                                                          |
// +-----------------------------------------------------------------+
package sdram_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_HOST    = 2'd1,
    ST_REFRESH = 2'd2
  } arb_state_t;

  // 7.8 us at 100 MHz; postpone limit of 8 follows the JEDEC allowance
  localparam int unsigned c_refresh_interval_cycles = 780;
  localparam int unsigned c_urgent_threshold        = 4;
  localparam int unsigned c_max_pending             = 8;

endpackage
`default_nettype wire

// File: rtl/sdram_refresh_timer.sv
`default_nettype none
// +-----------------------------------------------------------------+
// | sdram_refresh_timer : refresh interval timer, owed-refresh count |
// | Rev 1.0                                                          |
// +-----------------------------------------------------------------+
module sdram_refresh_timer
  import sdram_ctrl_pkg::*;
#(
  parameter  int unsigned REFRESH_INTERVAL_CYCLES = c_refresh_interval_cycles,
  parameter  int unsigned MAX_PENDING             = c_max_pending,
  localparam int unsigned PEND_W                  = $clog2(MAX_PENDING + 1),
  localparam int unsigned TIMER_W                 = $clog2(REFRESH_INTERVAL_CYCLES)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_tick_en,
  input  logic              i_ack,
  output logic [PEND_W-1:0] o_pending,
  output logic              o_overflow
);

  localparam logic [TIMER_W-1:0] c_reload = TIMER_W'(REFRESH_INTERVAL_CYCLES - 1);
  localparam logic [PEND_W-1:0]  c_max    = PEND_W'(MAX_PENDING);

  logic [TIMER_W-1:0] r_timer;
  logic [PEND_W-1:0]  r_pending;
  logic               r_overflow;
  logic               w_tick;
  logic               w_dec;

  assign w_tick = i_tick_en && (r_timer == '0);
  assign w_dec  = i_ack && (r_pending != '0);

  always_ff @(posedge clk) begin
    if (rst || !i_tick_en || w_tick) begin
      r_timer <= c_reload;
    end else begin
      r_timer <= r_timer - 1'b1;
    end
  end

  // A simultaneous tick and ack cancel; a tick lost at saturation is sticky
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pending  <= '0;
      r_overflow <= 1'b0;
    end else begin
      case ({w_tick, w_dec})
        2'b10: begin
          if (r_pending == c_max) begin
            r_overflow <= 1'b1;
          end else begin
            r_pending <= r_pending + 1'b1;
          end
        end
        2'b01:   r_pending <= r_pending - 1'b1;
        default: r_pending <= r_pending;
      endcase
    end
  end

  assign o_pending  = r_pending;
  assign o_overflow = r_overflow;

endmodule
`default_nettype wire

// File: rtl/sdram_refresh_arbiter.sv
`default_nettype none
// +-----------------------------------------------------------------+
// | sdram_refresh_arbiter : shares SDRAM command FSM, host vs refresh|
// | Rev 1.0                                                          |
// +-----------------------------------------------------------------+
module sdram_refresh_arbiter
  import sdram_ctrl_pkg::*;
#(
  parameter  int unsigned REFRESH_INTERVAL_CYCLES = c_refresh_interval_cycles,
  parameter  int unsigned URGENT_THRESHOLD        = c_urgent_threshold,
  parameter  int unsigned MAX_PENDING             = c_max_pending,
  localparam int unsigned PEND_W                  = $clog2(MAX_PENDING + 1)
) (
  input  logic              HCLK,
  input  logic              HRESET,
  input  logic              init_done_i,
  input  logic              ahb_req_i,
  input  logic              ahb_done_i,
  output logic              ahb_grant_o,
  output logic              ref_req_o,
  input  logic              ref_ack_i,
  output logic [PEND_W-1:0] pending_o,
  output logic              overflow_o
);

  localparam logic [PEND_W-1:0] c_urgent = PEND_W'(URGENT_THRESHOLD);

  arb_state_t        r_state;
  arb_state_t        w_next;
  logic              r_grant;
  logic              r_ref_req;
  logic              w_ack_valid;
  logic [PEND_W-1:0] w_pending;
  logic              w_overflow;

  // Acks arriving outside a refresh visit must not retire an owed refresh
  assign w_ack_valid = ref_ack_i && (r_state == ST_REFRESH);

  sdram_refresh_timer #(
    .REFRESH_INTERVAL_CYCLES (REFRESH_INTERVAL_CYCLES),
    .MAX_PENDING             (MAX_PENDING)
  ) u_timer (
    .clk        (HCLK),
    .rst        (HRESET),
    .i_tick_en  (init_done_i),
    .i_ack      (w_ack_valid),
    .o_pending  (w_pending),
    .o_overflow (w_overflow)
  );

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: begin
        if (init_done_i) begin
          if (w_pending >= c_urgent) begin
            w_next = ST_REFRESH;
          end else if (ahb_req_i) begin
            w_next = ST_HOST;
          end else if (w_pending != '0) begin
            w_next = ST_REFRESH;
          end
        end
      end
      ST_HOST:    if (ahb_done_i) w_next = ST_IDLE;
      ST_REFRESH: if (ref_ack_i)  w_next = ST_IDLE;
      default:    w_next = ST_IDLE;
    endcase
  end

  // Outputs are flopped from the next state so they align with r_state
  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      r_state   <= ST_IDLE;
      r_grant   <= 1'b0;
      r_ref_req <= 1'b0;
    end else begin
      r_state   <= w_next;
      r_grant   <= (w_next == ST_HOST);
      r_ref_req <= (w_next == ST_REFRESH);
    end
  end

  assign ahb_grant_o = r_grant;
  assign ref_req_o   = r_ref_req;
  assign pending_o   = w_pending;
  assign overflow_o  = w_overflow;

endmodule
`default_nettype wire

// File: tb/tb_sdram_refresh_arbiter.sv
`default_nettype none
// +-----------------------------------------------------------------+
// | tb_sdram_refresh_arbiter : directed bench, INTERVAL=16 URGENT=2  |
// | MAX=4. Rev 1.0                                                   |
// +-----------------------------------------------------------------+
module tb_sdram_refresh_arbiter;

  logic       HCLK;
  logic       HRESET;
  logic       init_done_i;
  logic       ahb_req_i;
  logic       ahb_done_i;
  logic       ahb_grant_o;
  logic       ref_req_o;
  logic       ref_ack_i;
  logic [2:0] pending_o;
  logic       overflow_o;

  int n_checks = 0;
  int n_errors = 0;

  sdram_refresh_arbiter #(
    .REFRESH_INTERVAL_CYCLES (16),
    .URGENT_THRESHOLD        (2),
    .MAX_PENDING             (4)
  ) dut (
    .HCLK        (HCLK),
    .HRESET      (HRESET),
    .init_done_i (init_done_i),
    .ahb_req_i   (ahb_req_i),
    .ahb_done_i  (ahb_done_i),
    .ahb_grant_o (ahb_grant_o),
    .ref_req_o   (ref_req_o),
    .ref_ack_i   (ref_ack_i),
    .pending_o   (pending_o),
    .overflow_o  (overflow_o)
  );

  initial HCLK = 1'b0;
  always #5 HCLK = ~HCLK;

  task automatic step();
    @(posedge HCLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  initial begin
    HRESET = 1'b1; init_done_i = 1'b0; ahb_req_i = 1'b0;
    ahb_done_i = 1'b0; ref_ack_i = 1'b0;
    repeat (3) step();
    chk("rst_grant",    32'(ahb_grant_o), 0);
    chk("rst_ref_req",  32'(ref_req_o),   0);
    chk("rst_pending",  32'(pending_o),   0);
    chk("rst_overflow", 32'(overflow_o),  0);
    HRESET = 1'b0;

    // no init: nothing happens
    for (int i = 0; i < 100; i++) begin
      step();
      chk("noinit_pending", 32'(pending_o), 0);
      chk("noinit_active",  32'(ref_req_o | ahb_grant_o), 0);
    end

    // init rises (E0); first tick at E16, request at E17
    init_done_i = 1'b1;
    repeat (16) step();
    chk("first_tick_pending", 32'(pending_o), 1);
    chk("first_tick_noreq",   32'(ref_req_o), 0);
    step();
    chk("first_ref_req", 32'(ref_req_o), 1);
    repeat (2) step();
    ref_ack_i = 1'b1; step(); ref_ack_i = 1'b0;           // E20
    chk("ack1_pending", 32'(pending_o), 0);
    chk("ack1_req_drop", 32'(ref_req_o), 0);
    repeat (12) step();                                    // E32
    chk("tick2_pending", 32'(pending_o), 1);
    chk("tick2_noreq",   32'(ref_req_o), 0);
    step();
    chk("tick2_ref_req", 32'(ref_req_o), 1);
    repeat (2) step();
    ref_ack_i = 1'b1; step(); ref_ack_i = 1'b0;           // E36
    chk("ack2_pending", 32'(pending_o), 0);

    // host wins at pending=1; stray ack in HOST ignored
    repeat (12) step();                                    // E48
    chk("tick3_pending", 32'(pending_o), 1);
    ahb_req_i = 1'b1; step();                              // E49
    chk("host_wins_grant", 32'(ahb_grant_o), 1);
    chk("host_wins_noref", 32'(ref_req_o),   0);
    ahb_req_i = 1'b0; ref_ack_i = 1'b1; step(); ref_ack_i = 1'b0;  // E50
    chk("host_no_preempt", 32'(ahb_grant_o), 1);
    chk("stray_ack",       32'(pending_o),   1);
    ahb_done_i = 1'b1; step(); ahb_done_i = 1'b0;          // E51
    chk("host_done_drop", 32'(ahb_grant_o), 0);
    chk("gap_noref",      32'(ref_req_o),   0);
    step();                                                // E52
    chk("after_host_ref", 32'(ref_req_o), 1);
    ref_ack_i = 1'b1; step(); ref_ack_i = 1'b0;            // E53
    chk("ack3_pending", 32'(pending_o), 0);

    // continuous host traffic until pending reaches urgency
    ahb_req_i = 1'b1;
    for (int b = 0; b < 6; b++) begin
      step();
      chk("burst_grant", 32'(ahb_grant_o), 1);
      repeat (3) step();
      ahb_done_i = 1'b1; step(); ahb_done_i = 1'b0;
      chk("burst_gap", 32'(ahb_grant_o), 0);
    end                                                    // E83
    chk("urgent_pending", 32'(pending_o), 2);
    chk("urgent_noref_yet", 32'(ref_req_o), 0);
    step();                                                // E84
    chk("urgent_ref_req", 32'(ref_req_o),   1);
    chk("urgent_nogrant", 32'(ahb_grant_o), 0);
    repeat (2) step();
    chk("urgent_hold_nogrant", 32'(ahb_grant_o), 0);
    ref_ack_i = 1'b1; step(); ref_ack_i = 1'b0;            // E87
    chk("urgent_ack_pending", 32'(pending_o), 1);
    chk("urgent_ack_drop",    32'(ref_req_o), 0);
    step();                                                // E88
    chk("regrant_host", 32'(ahb_grant_o), 1);
    repeat (3) step();
    ahb_done_i = 1'b1; ahb_req_i = 1'b0; step(); ahb_done_i = 1'b0;  // E92
    chk("regrant_done", 32'(ahb_grant_o), 0);

    // no acks: saturation and sticky overflow
    repeat (51) step();                                    // E143
    chk("sat_pending",  32'(pending_o),  4);
    chk("sat_no_ovf",   32'(overflow_o), 0);
    chk("sat_ref_held", 32'(ref_req_o),  1);
    step();                                                // E144
    chk("ovf_set",     32'(overflow_o), 1);
    chk("ovf_pending", 32'(pending_o),  4);
    repeat (28) step();                                    // E172
    chk("ovf_pending_late", 32'(pending_o), 4);
    ref_ack_i = 1'b1; step(); ref_ack_i = 1'b0;            // E173
    chk("ovf_ack_pending", 32'(pending_o),  3);
    chk("ovf_sticky",      32'(overflow_o), 1);
    chk("ovf_ack_drop",    32'(ref_req_o),  0);

    // tick coincident with ack
    step();                                                // E174
    chk("coinc_ref_req", 32'(ref_req_o), 1);
    step();
    ref_ack_i = 1'b1; step(); ref_ack_i = 1'b0;            // E176
    chk("coinc_pending", 32'(pending_o), 3);
    step();                                                // E177
    chk("coinc_rereq", 32'(ref_req_o), 1);
    ref_ack_i = 1'b1; step(); ref_ack_i = 1'b0;            // E178
    step();                                                // E179
    ref_ack_i = 1'b1; step(); ref_ack_i = 1'b0;            // E180
    chk("drain_pending", 32'(pending_o), 1);

    // reset while in HOST
    ahb_req_i = 1'b1; step();                              // E181
    chk("pre_rst_grant", 32'(ahb_grant_o), 1);
    HRESET = 1'b1; step(); HRESET = 1'b0;                  // E182
    chk("midrst_grant",    32'(ahb_grant_o), 0);
    chk("midrst_pending",  32'(pending_o),   0);
    chk("midrst_overflow", 32'(overflow_o),  0);
    chk("midrst_ref_req",  32'(ref_req_o),   0);

    // init dropped: request never granted
    init_done_i = 1'b0;
    repeat (20) step();
    chk("noinit2_grant",   32'(ahb_grant_o), 0);
    chk("noinit2_pending", 32'(pending_o),   0);
    chk("noinit2_ref_req", 32'(ref_req_o),   0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
